// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizes for the pulse-burst sequencer.
package pulse_seq_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_seq_timebase.sv
// Period counter for the pulse sequencer.
// The counter counts 0..period-1 and o_wrap is registered high on the last count.
// load latches a new period and restarts at 0.
// clr forces count and wrap to 0 but keeps the latched period.
module pulse_seq_timebase
  import pulse_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] w_last;

  // Next count value and the terminal count for the latched period.
  always_comb begin
    w_count_inc = r_wrap ? '0 : r_count + 1'b1;
    w_last      = r_period - 1'b1;
  end

  // Counter register; load has priority over clear, clear over enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period <= '0;
      r_count  <= '0;
      r_wrap   <= 1'b0;
    end else if (i_load) begin
      r_period <= i_period;
      r_count  <= '0;
      r_wrap   <= (i_period == WIDTH'(1));
    end else if (i_clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_en) begin
      r_count <= w_count_inc;
      r_wrap  <= (w_count_inc == w_last);
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Programmable pulse-burst generator: runs BURST periods of PERIOD cycles,
// PULSE high for the first HIGH_T cycles of each period, TC on each wrap,
// DONE strobe after the last period. All outputs are registered.
// Optional sticky completion interrupt: define PULSE_SEQ_IRQ_EN.
//
//  state | meaning
//  IDLE  | waiting for an acceptable START
//  RUN   | burst in progress, period counter running
//  FIN   | one-cycle DONE strobe, then back to IDLE
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_high_t,
  input  logic [CNT_W-1:0] i_burst,
  output logic             o_busy,
  output logic             o_pulse,
  output logic             o_tc,
  output logic             o_done,
`ifdef PULSE_SEQ_IRQ_EN
  output logic             o_irq,
  input  logic             i_irq_clr,
`endif
  output logic [WIDTH-1:0] o_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_high_t;
  logic [CNT_W-1:0] r_remaining;
  logic             w_accept;

  logic [WIDTH-1:0] w_count;
  logic             w_wrap;
  logic             w_tb_load;
  logic             w_tb_clr;
  logic             w_tb_en;

  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_high_nxt;
  logic             w_busy_nxt;
  logic             w_pulse_nxt;
  logic             w_done_nxt;
  logic             r_busy;
  logic             r_pulse;
  logic             r_done;

  // A start is only taken from IDLE, without STOP, and with a non-empty burst.
  assign w_accept = (r_state == ST_IDLE) && i_start && !i_stop &&
                    (i_period != '0) && (i_burst != '0);

  pulse_seq_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_tb_load),
    .i_clr    (w_tb_clr),
    .i_en     (w_tb_en),
    .i_period (i_period),
    .o_count  (w_count),
    .o_wrap   (w_wrap)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; STOP overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_wrap && (r_remaining == CNT_W'(1))) w_state_nxt = ST_FIN;
        ST_FIN:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs plus timebase controls.
  // Outputs are computed from the next state so they line up with it.
  always_comb begin
    w_count_nxt = '0;
    w_high_nxt  = w_accept ? i_high_t : r_high_t;
    w_busy_nxt  = 1'b0;
    w_pulse_nxt = 1'b0;
    w_done_nxt  = (w_state_nxt == ST_FIN);
    w_tb_load   = w_accept;
    w_tb_clr    = (w_state_nxt != ST_RUN);
    w_tb_en     = (r_state == ST_RUN);
    if (w_state_nxt == ST_RUN) begin
      if (!w_accept && !w_wrap) begin
        w_count_nxt = w_count + 1'b1;
      end
      w_busy_nxt  = 1'b1;
      w_pulse_nxt = (w_count_nxt < w_high_nxt);
    end
  end

  // Burst configuration latch and remaining-period counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_high_t    <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_high_t    <= i_high_t;
      r_remaining <= i_burst;
    end else if ((r_state == ST_RUN) && w_wrap && !i_stop) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  // Registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_pulse <= w_pulse_nxt;
      r_done  <= w_done_nxt;
    end
  end

`ifdef PULSE_SEQ_IRQ_EN
  logic r_irq;

  // Sticky completion flag; raised with DONE and held through the DONE
  // cycle so a clear coinciding with DONE loses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (w_done_nxt || r_done) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`endif

  assign o_busy  = r_busy;
  assign o_pulse = r_pulse;
  assign o_tc    = w_wrap;
  assign o_done  = r_done;
  assign o_count = w_count;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl; expectations computed from the burst
// parameters (count = i mod P, pulse = count < H, tc = count == P-1).
`timescale 1ns/1ps
module tb_pulse_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] period;
  logic [3:0] high_t;
  logic [7:0] burst;
  logic       busy;
  logic       pulse;
  logic       tc;
  logic       done;
  logic [3:0] count;
`ifdef PULSE_SEQ_IRQ_EN
  logic       irq;
  logic       irq_clr;
`endif

  int n_checks;
  int n_pass;

  pulse_seq_ctrl #(.WIDTH(4), .CNT_W(8)) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_stop   (stop),
    .i_period (period),
    .i_high_t (high_t),
    .i_burst  (burst),
    .o_busy   (busy),
    .o_pulse  (pulse),
    .o_tc     (tc),
    .o_done   (done),
`ifdef PULSE_SEQ_IRQ_EN
    .o_irq    (irq),
    .i_irq_clr(irq_clr),
`endif
    .o_count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int p, input int h, input int b);
    period = 4'(p);
    high_t = 4'(h);
    burst  = 8'(b);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Follows a burst already started; optionally pokes START with a different
  // PERIOD at cycle index poke (negative = never).
  task automatic expect_burst(input int p, input int h, input int b, input int poke);
    int c;
    for (int i = 0; i < p * b; i++) begin
      c = i % p;
      check("busy", 32'(busy), 32'd1);
      check("count", 32'(count), 32'(c));
      check("pulse", 32'(pulse), 32'(c < h));
      check("tc", 32'(tc), 32'(c == p - 1));
      check("done_run", 32'(done), 32'd0);
      if (i == poke) begin
        start  = 1'b1;
        period = 4'd2;
      end
      tick();
      start = 1'b0;
    end
    check("done_fin", 32'(done), 32'd1);
    check("busy_fin", 32'(busy), 32'd0);
    check("pulse_fin", 32'(pulse), 32'd0);
    check("count_fin", 32'(count), 32'd0);
    tick();
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    period = 4'd0;
    high_t = 4'd0;
    burst  = 8'd0;
`ifdef PULSE_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic burst
    start_burst(4, 1, 3);
    expect_burst(4, 1, 3, -1);

    // async reset mid-burst
    start_burst(4, 2, 3);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulse", 32'(pulse), 32'd0);
    check("arst_tc", 32'(tc), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    tick();

    // zero period / zero burst rejected
    start_burst(0, 1, 3);
    check("p0_busy", 32'(busy), 32'd0);
    tick();
    check("p0_done", 32'(done), 32'd0);
    start_burst(3, 1, 0);
    check("b0_busy", 32'(busy), 32'd0);
    tick();
    check("b0_done", 32'(done), 32'd0);

    // HIGH_T >= PERIOD, HIGH_T = 0, PERIOD = 1
    start_burst(4, 5, 2);
    expect_burst(4, 5, 2, -1);
    start_burst(3, 0, 2);
    expect_burst(3, 0, 2, -1);
    start_burst(1, 1, 3);
    expect_burst(1, 1, 3, -1);

    // STOP in cycle 6
    start_burst(4, 2, 5);
    for (int i = 0; i < 5; i++) tick();
    check("pre_stop_count", 32'(count), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_pulse", 32'(pulse), 32'd0);
    check("stop_count", 32'(count), 32'd0);
    check("stop_tc", 32'(tc), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stop_no_done", 32'(done | busy), 32'd0);
    end

    // STOP at a TC cycle
    start_burst(2, 1, 3);
    tick();
    check("tc_before_stop", 32'(tc), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_tc_busy", 32'(busy), 32'd0);
    check("stop_tc_tc", 32'(tc), 32'd0);
    tick();
    check("stop_tc_done", 32'(done), 32'd0);

    // START with STOP
    period = 4'd4;
    high_t = 4'd1;
    burst  = 8'd2;
    start  = 1'b1;
    stop   = 1'b1;
    tick();
    start  = 1'b0;
    stop   = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    tick();
    check("startstop_busy2", 32'(busy), 32'd0);

    // START during RUN ignored
    start_burst(4, 2, 2);
    expect_burst(4, 2, 2, 2);

`ifdef PULSE_SEQ_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 32'd0);
    start_burst(2, 1, 1);
    tick();
    check("irq_pre", 32'(irq), 32'd0);
    irq_clr = 1'b1;
    tick();
    check("irq_with_done", 32'(done), 32'd1);
    check("irq_rise", 32'(irq), 32'd1);
    tick();
    irq_clr = 1'b0;
    check("irq_set_wins", 32'(irq), 32'd1);
    tick();
    check("irq_hold", 32'(irq), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
